hazard_forward_unit: RTL



---
 rtl/hazard_forward_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/hazard_forward_unit.sv
// Forwarding select, load-use stall and data-memory wait hold for the EX stage.
// Define FWD_WB_HIST_EN to add the one-entry post-WB history path (code 11).
module hazard_forward_unit #(
   parameter int NUM_SRC  = 2,
   parameter int REG_W    = 5,
   parameter int DATA_W   = 32,
   parameter int LOAD_LAT = 1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [NUM_SRC*REG_W-1:0]   ID_Rs_i,
   input  logic [NUM_SRC-1:0]         ID_Use_i,
   input  logic [NUM_SRC*REG_W-1:0]   EX_Rs_i,
   input  logic                       EX_MemRead_i,
   input  logic [REG_W-1:0]           EX_Rd_i,
   input  logic                       MEM_RegWrite_i,
   input  logic                       MEM_MemRead_i,
   input  logic [REG_W-1:0]           MEM_Rd_i,
   input  logic                       WB_RegWrite_i,
   input  logic [REG_W-1:0]           WB_Rd_i,
   input  logic [DATA_W-1:0]          WB_Data_i,
   output logic [NUM_SRC*2-1:0]       Forward_o,
   output logic [DATA_W-1:0]          HistData_o,
   output logic                       Stall_o,
   output logic                       Bubble_o,
   output logic                       Hold_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_REL
   } state_t;

   localparam bit       HAS_LAT = (LOAD_LAT > 0);
   localparam logic [2:0] LAT_M1 =
      HAS_LAT ? 3'(LOAD_LAT - 1) : 3'd0;

   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic       hold;
   logic       hist_vld;
   logic [REG_W-1:0] hist_rd;
   logic       lu_hit;

   // First hold cycle coincides with the load sitting in MEM.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      hold    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (MEM_MemRead_i && HAS_LAT) begin
               hold    = 1'b1;
               cnt_d   = LAT_M1;
               state_d = (LOAD_LAT == 1) ? S_REL : S_WAIT;
            end
         end
         S_WAIT: begin
            hold  = 1'b1;
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
               state_d = S_REL;
            end
         end
         S_REL: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      if (rst_i) begin
         state_d = S_IDLE;
         cnt_d   = 3'd0;
         hold    = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef FWD_WB_HIST_EN
   logic              hist_vld_q;
   logic [REG_W-1:0]  hist_rd_q;
   logic [DATA_W-1:0] hist_data_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hist_vld_q  <= 1'b0;
         hist_rd_q   <= '0;
         hist_data_q <= '0;
      end else if (!hold) begin
         hist_vld_q  <= WB_RegWrite_i && (WB_Rd_i != '0);
         hist_rd_q   <= WB_Rd_i;
         hist_data_q <= WB_Data_i;
      end
   end

   assign hist_vld    = hist_vld_q;
   assign hist_rd     = hist_rd_q;
   assign HistData_o  = hist_data_q;
`else
   logic unused_wb_data;

   assign unused_wb_data = ^WB_Data_i;
   assign hist_vld       = 1'b0;
   assign hist_rd        = '0;
   assign HistData_o     = '0;
`endif

   always_comb begin : p_fwd
      logic [REG_W-1:0] rs;
      rs        = '0;
      Forward_o = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         rs = EX_Rs_i[k*REG_W +: REG_W];
         if (MEM_RegWrite_i && (MEM_Rd_i != '0) && (MEM_Rd_i == rs)) begin
            Forward_o[k*2 +: 2] = 2'b10;
         end else if (WB_RegWrite_i && (WB_Rd_i != '0) && (WB_Rd_i == rs)) begin
            Forward_o[k*2 +: 2] = 2'b01;
         end else if (hist_vld && (hist_rd == rs)) begin
            Forward_o[k*2 +: 2] = 2'b11;
         end
      end
      if (rst_i) begin
         Forward_o = '0;
      end
   end

   always_comb begin
      lu_hit = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (ID_Use_i[k] && (ID_Rs_i[k*REG_W +: REG_W] == EX_Rd_i)) begin
            lu_hit = 1'b1;
         end
      end
      lu_hit = lu_hit && EX_MemRead_i && (EX_Rd_i != '0);
   end

   assign Hold_o   = hold;
   assign Stall_o  = lu_hit && !hold && !rst_i;
   assign Bubble_o = Stall_o;

endmodule
